// File: rtl/restador_serial.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell feeds a borrow flip-flop; start/busy/done
// handshake frames each operation.
module restador_serial #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] diff;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d_bit     = ra[0] ^ rb[0] ^ br;
        br_next   = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        diff_next = {d_bit, diff[WIDTH-1:1]};
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM, operand/diff shifters and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            diff  <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= A;
                        rb    <= B;
                        br    <= Bin;
                        // MSBs kept aside: ra/rb are consumed by shifting.
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    ra   <= ra >> 1;
                    rb   <= rb >> 1;
                    br   <= br_next;
                    diff <= diff_next;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        D     <= diff_next;
                        Bout  <= br_next;
                        // d_bit is the result MSB on the final step.
                        Ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial with an expected-result scoreboard.
module tb_restador_serial;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Ovf;

    int n_vec = 0;
    int n_err = 0;

    // Expected {D, Bout, Ovf} per launched operation.
    logic [WIDTH+1:0] sb_q[$];

    restador_serial #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .busy (busy),
        .done (done),
        .D    (D),
        .Bout (Bout),
        .Ovf  (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic bi);
        int ua, ub, sa, sb, ur, sr;
        logic [WIDTH-1:0] dd;
        logic bo, ov;
        ua = int'(a);
        ub = int'(b);
        sa = a[WIDTH-1] ? ua - (1 << WIDTH) : ua;
        sb = b[WIDTH-1] ? ub - (1 << WIDTH) : ub;
        ur = ua - ub - int'(bi);
        sr = sa - sb - int'(bi);
        dd = ur[WIDTH-1:0];
        bo = (ur < 0);
        ov = (sr < -(1 << (WIDTH - 1))) || (sr > (1 << (WIDTH - 1)) - 1);
        return {dd, bo, ov};
    endfunction

    // Drive a one-cycle start; caller must be away from the clock edge.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bi);
        A     = a;
        B     = b;
        Bin   = bi;
        start = 1'b1;
        sb_q.push_back(model(a, b, bi));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, checking busy length, D hold during CALC, result and pulse width.
    task automatic wait_done(input string tag, input int exp_busy,
                             input logic [WIDTH-1:0] held_d);
        int nbusy;
        bit seen;
        bit held_ok;
        logic [WIDTH+1:0] exp;
        nbusy   = 0;
        seen    = 0;
        held_ok = 1;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                nbusy++;
                if (D !== held_d) held_ok = 0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_busy_cycles"}, nbusy, exp_busy);
            check({tag, "_d_held"}, 32'(held_ok), 32'd1);
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check({tag, "_D"}, 32'(D), 32'(exp[WIDTH+1:2]));
                check({tag, "_Bout"}, 32'(Bout), 32'(exp[1]));
                check({tag, "_Ovf"}, 32'(Ovf), 32'(exp[0]));
            end
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] last_d;
        logic [WIDTH-1:0] ra, rb;
        logic rbi;
        int extra_done;
        bit held_ok;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_Ovf", 32'(Ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, launched back to back at the earliest legal edge.
        launch(8'h05, 8'h03, 1'b0); wait_done("v05m03", WIDTH, 8'h00);
        launch(8'h03, 8'h05, 1'b0); wait_done("v03m05", WIDTH, 8'h02);
        launch(8'h80, 8'h01, 1'b0); wait_done("v80m01", WIDTH, 8'hFE);
        launch(8'h7F, 8'hFF, 1'b0); wait_done("v7FmFF", WIDTH, 8'h7F);
        launch(8'h00, 8'h00, 1'b1); wait_done("v00m00b", WIDTH, 8'h80);
        launch(8'hFF, 8'hFF, 1'b0); wait_done("vFFmFF", WIDTH, 8'hFF);
        last_d = D;

        // Random vectors.
        for (int i = 0; i < 8; i++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rbi = 1'($urandom);
            launch(ra, rb, rbi);
            wait_done("rand", WIDTH, last_d);
            last_d = D;
        end

        // Start during CALC is ignored; operands changing mid-op have no effect.
        launch(8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        A     = 8'hAA;
        B     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", WIDTH - 3, last_d);
        check("ignore_D", 32'(D), 32'h0F);
        extra_done = 0;
        held_ok    = 1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (D !== 8'h0F) held_ok = 0;
        end
        check("ignore_no_second_done", extra_done, 0);
        check("ignore_D_held_idle", 32'(held_ok), 32'd1);
        launch(8'h20, 8'h05, 1'b0);
        wait_done("after_ignore", WIDTH, 8'h0F);

        // Reset mid-operation aborts immediately.
        launch(8'h44, 8'h11, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(D), 32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        check("abort_Ovf", 32'(Ovf), 32'd0);
        void'(sb_q.pop_back());
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("abort_no_done", extra_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        launch(8'h09, 8'h04, 1'b0);
        wait_done("post_rst", WIDTH, 8'h00);
        check("post_rst_D", 32'(D), 32'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
